// File: rtl/misr_sig_compactor.sv
// Multiple-input signature register: compacts a handshaked stream of response
// vectors into one signature and compares it against an expected value.
module misr_sig_compactor #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'h3,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [WIDTH-1:0] exp_sig_q, exp_sig_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] sig_step;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
  endfunction

  assign sig_step = misr_step(sig_q, in_data);
  assign cnt_inc  = vec_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    exp_sig_d = exp_sig_q;
    pass_d    = pass_q;
    case (state_q)
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (in_valid) begin
          sig_d     = sig_step;
          vec_cnt_d = cnt_inc;
          if (cnt_inc == num_vec_q) begin
            state_d = DONE;
            pass_d  = (sig_step == exp_sig_q);
          end
        end
      end
      default: begin
        // IDLE and DONE share the start/load behaviour; DONE otherwise falls to IDLE.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          sig_d     = SEED;
          vec_cnt_d = '0;
          num_vec_d = num_vec;
          exp_sig_d = exp_sig;
          if (num_vec == '0) begin
            state_d = DONE;
            pass_d  = (SEED == exp_sig);
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      exp_sig_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      vec_cnt_q <= vec_cnt_d;
      num_vec_q <= num_vec_d;
      exp_sig_q <= exp_sig_d;
      pass_q    <= pass_d;
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign sig      = sig_q;
  assign vec_cnt  = vec_cnt_q;

endmodule

// File: tb/tb_misr_sig_compactor.sv
// Randomised scoreboard bench for misr_sig_compactor against a polynomial
// arithmetic model of the signature (multiply by x modulo P(x), add vector).
module tb_misr_sig_compactor;
  localparam int W = 4;
  localparam int C = 16;
  localparam logic [W:0] FULL_POLY = 5'b10011;  // x^4 + x + 1

  logic         clk = 0;
  logic         rst, start, abort, in_valid;
  logic [C-1:0] num_vec;
  logic [W-1:0] exp_sig, in_data;
  logic         in_ready, busy, done, pass;
  logic [W-1:0] sig;
  logic [C-1:0] vec_cnt;

  misr_sig_compactor #(.WIDTH(W), .POLY(4'h3), .SEED(4'h0), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vec(num_vec),
    .exp_sig(exp_sig), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .busy(busy), .done(done), .pass(pass), .sig(sig),
    .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         p;
    logic [C-1:0] n;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_sig, m_exp;
  logic [C-1:0] m_cnt, m_nv;
  logic [W-1:0] vec_buf[$];

  function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ FULL_POLY;
    return t[W-1:0] ^ d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued run result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_sig", sig, e.s);
        chk("done_pass", pass, e.p);
        chk("done_cnt", vec_cnt, e.n);
        $display("run result: sig=%0h pass=%0b cnt=%0d (model sig=%0h pass=%0b cnt=%0d)",
                 sig, pass, vec_cnt, e.s, e.p, e.n);
      end
    end
  end

  task automatic model_load(input logic [C-1:0] nv, input logic [W-1:0] ex);
    m_sig = 4'h0; m_cnt = '0; m_nv = nv; m_exp = ex;
    if (nv == 0) sb_q.push_back('{s: 4'h0, p: (m_exp == 4'h0), n: '0});
  endtask

  task automatic start_run(input logic [C-1:0] nv, input logic [W-1:0] ex);
    start = 1; num_vec = nv; exp_sig = ex;
    model_load(nv, ex);
    tick();
    start = 0;
  endtask

  // Feed n vectors from vec_buf, idling on random cycles with probability gap%.
  task automatic feed(input int n, input int gap);
    int i, budget;
    logic rdy, v;
    i = 0; budget = 0;
    while (i < n) begin
      v = ($urandom_range(99) >= gap);
      in_valid = v; in_data = vec_buf[i];
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (v && rdy) begin
        m_sig = model_step(m_sig, vec_buf[i]);
        m_cnt = m_cnt + 1;
        i++;
        if (m_cnt == m_nv) sb_q.push_back('{s: m_sig, p: (m_sig == m_exp), n: m_cnt});
      end
      in_valid = 0;
      if (++budget > 2000) begin
        chk("feed_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    chk("sig_after_feed", sig, m_sig);
    chk("cnt_after_feed", vec_cnt, m_cnt);
    if (m_cnt == m_nv) chk("done_latency", done, 1);
    tick();
  endtask

  task automatic fill(input int n, input logic [W-1:0] fixed, input bit rnd);
    vec_buf.delete();
    for (int k = 0; k < n; k++) vec_buf.push_back(rnd ? W'($urandom_range(15)) : fixed);
  endtask

  task automatic check_idle_reset();
    @(negedge clk);
    chk("rst_sig", sig, 0);
    chk("rst_cnt", vec_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ready", in_ready, 0);
    tick();
  endtask

  initial begin
    logic [W-1:0] s;
    int nv;
    rst = 1; start = 0; abort = 0; in_valid = 0; in_data = 0; num_vec = 0; exp_sig = 0;
    tick(); tick();
    rst = 0;
    check_idle_reset();

    // Valid data in IDLE must not be consumed.
    in_valid = 1; in_data = 4'h5;
    tick(); tick();
    @(negedge clk);
    chk("idle_no_accept_sig", sig, 0);
    chk("idle_no_accept_cnt", vec_cnt, 0);
    tick();
    in_valid = 0;

    // Four 1s: 1,3,7,F and pass.
    fill(4, 4'h1, 0);
    start_run(4, 4'hF);
    feed(4, 0);
    // Five 1s: MSB feedback F->C, pass low and held.
    fill(5, 4'h1, 0);
    start_run(5, 4'hF);
    feed(5, 0);
    tick(); tick();
    @(negedge clk);
    chk("pass_held_low", pass, 0);
    tick();

    // Gapped input stream.
    fill(3, 0, 1);
    start_run(3, 4'h0);
    feed(3, 60);

    // Abort coinciding with a valid vector after 2 of 5.
    fill(5, 0, 1);
    start_run(5, 4'h0);
    feed(2, 0);
    in_valid = 1; in_data = 4'hA; abort = 1;
    tick();
    abort = 0; in_valid = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", vec_cnt, 2);
    chk("abort_sig", sig, m_sig);
    chk("abort_pass", pass, 0);
    tick(); tick();

    // num_vec=0, then start held through DONE with num_vec=2.
    start = 1; num_vec = 0; exp_sig = 4'h0;
    model_load(0, 4'h0);
    tick();
    num_vec = 2; exp_sig = 4'h6;
    model_load(2, 4'h6);
    tick();
    start = 0;
    @(negedge clk);
    chk("restart_from_done_busy", busy, 1);
    tick();
    fill(2, 0, 1);
    feed(2, 0);

    // Reset mid-run after 3 accepts, then repeat the first scenario.
    fill(5, 0, 1);
    start_run(5, 4'h0);
    feed(3, 0);
    rst = 1;
    tick();
    rst = 0;
    check_idle_reset();
    fill(4, 4'h1, 0);
    start_run(4, 4'hF);
    feed(4, 0);
    chk("repeat_final_sig", m_sig, 4'hF);

    // Random runs, expected signature matching about half the time.
    for (int r = 0; r < 12; r++) begin
      nv = $urandom_range(1, 20);
      fill(nv, 0, 1);
      s = 4'h0;
      for (int k = 0; k < nv; k++) s = model_step(s, vec_buf[k]);
      start_run(C'(nv), ($urandom_range(1) != 0) ? s : W'($urandom_range(15)));
      feed(nv, $urandom_range(40));
      tick();
    end

    tick(); tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/misr_sig_compactor.md
Name: misr_sig_compactor

Overview:
- Parametrised multiple-input signature register (MISR) that compacts a stream of WIDTH-bit response vectors from a combinational circuit under test into one WIDTH-bit signature.
- Sits between the circuit-under-test output bus and the equivalence-check controller; replaces per-vector output comparison with one signature compare per run.
- Adds a valid/ready vector handshake, a programmable vector count, abort, and a registered pass/fail against an expected signature.

Parameters:
- WIDTH, 4, width of the response vector and of the signature (minimum 2).
- POLY, 4'h3, feedback taps; bit i set means bit i receives the shifted-out MSB (default is x^4+x+1).
- SEED, 0, signature value loaded on start and on reset.
- CNT_W, 16, width of the vector counter and of num_vec.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled only in IDLE and DONE.
- abort  in  1  cancel a run; effective only in RUN.
- num_vec  in  CNT_W  number of vectors in the run; sampled with start.
- exp_sig  in  WIDTH  expected signature; sampled with start.
- in_valid  in  1  in_data holds a vector.
- in_ready  out  1  block accepts a vector this cycle.
- in_data  in  WIDTH  response vector.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  final signature equalled exp_sig; held until the next start or reset.
- sig  out  WIDTH  current signature register.
- vec_cnt  out  CNT_W  vectors accepted in the current run.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) forces:
  - state to IDLE;
  - sig=SEED, vec_cnt=0;
  - busy=0, done=0, pass=0, in_ready=0;
  - the latched num_vec and exp_sig to 0.
- Reset overrides every other input on the same edge, including mid-RUN.
- FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- IDLE:
  - in_ready=0.
  - start=1 loads sig=SEED and vec_cnt=0, latches num_vec and exp_sig, and clears pass.
  - If num_vec==0, the next state is DONE. Otherwise the next state is RUN.
- RUN:
  - in_ready=1 and busy=1.
  - A vector is accepted on an edge where in_valid&in_ready=1. The update is sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ in_data, and vec_cnt increments by 1.
  - When the accepted vector makes vec_cnt equal to the latched num_vec, the next state is DONE.
  - in_valid=0 leaves sig and vec_cnt unchanged. The run stalls indefinitely; there is no timeout.
  - abort=1 goes to IDLE. sig and vec_cnt hold their values for debug, pass=0, and done is not asserted.
  - If abort and a valid transfer coincide, abort wins and the vector is not accepted.
  - start is ignored in RUN.
- DONE (exactly one cycle):
  - done=1, in_ready=0.
  - pass is registered as (sig==latched exp_sig) on entry to DONE, so it is valid in the same cycle as done.
  - Next state is IDLE. If start=1 in the DONE cycle, the next state is RUN (or DONE if num_vec==0), with the same load actions as IDLE.
- vec_cnt never wraps: num_vec is at most 2^CNT_W-1, and the run ends on equality.
- Latency:
  - start to in_ready is 1 cycle.
  - The last accepted vector to done is 1 cycle.
  - Sustained throughput is 1 vector per cycle.
- Vectors presented while in_ready=0 are not consumed. The source must hold in_valid and in_data until it sees a cycle with in_ready=1.

Test Plan:
- WIDTH=4, POLY=3, SEED=0; start with num_vec=4, exp_sig=4'hF; stream in_data=4'h1 ×4 back-to-back -> sig goes 1,3,7,F; done pulses 1 cycle after the 4th accept; pass=1.
- Same setup with num_vec=5, exp_sig=4'hF, five vectors of 4'h1 -> 5th accept exercises MSB feedback: F -> C; pass=0 and stays 0 through idle cycles until the next start.
- num_vec=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 accepts, vec_cnt increments only on accepted cycles, done 1 cycle after the 3rd accept; in_valid high in IDLE before start -> no accept, sig unchanged.
- abort asserted with in_valid=1 after 2 of 5 vectors -> IDLE next cycle; vec_cnt=2; done never pulses; pass=0; the simultaneous vector is not accepted.
- num_vec=0 -> done pulses the cycle after start, sig=SEED; start held high through the DONE cycle with num_vec=2 -> re-enters RUN without passing through IDLE.
- rst asserted mid-RUN after 3 accepts -> next cycle sig=0, vec_cnt=0, busy=0, pass=0, in_ready=0, state IDLE; a subsequent full run reproduces the first scenario exactly.
